// File: rtl/axis_dac_spi_seq_if.sv
// Input bundle for the DAC sequencer: per-channel sample stream plus the
// configuration-frame controls.
interface axis_dac_spi_seq_if #(
  parameter int NCH  = 4,
  parameter int IN_W = 32
);
  logic [NCH*IN_W-1:0] S_AXIS_tdata;
  logic [NCH-1:0]      S_AXIS_tvalid;
  logic [23:0]         S_AXISCFG_tdata;
  logic                configuration_mode;
  logic [2:0]          configuration_axis;
  logic                configuration_send;

  modport master (
    output S_AXIS_tdata, S_AXIS_tvalid, S_AXISCFG_tdata,
           configuration_mode, configuration_axis, configuration_send
  );
  modport slave (
    input  S_AXIS_tdata, S_AXIS_tvalid, S_AXISCFG_tdata,
           configuration_mode, configuration_axis, configuration_send
  );
endinterface

// File: rtl/axis_dac_spi_seq.sv
// Multi-channel AD5791-class SPI DAC sequencer: parallel SDI lanes on a shared
// SCLK/SYNC_n, common LDAC_n strobe, plus a single-channel config-frame path.
module axis_dac_spi_seq_lane #(
  parameter int DAC_W = 20
) (
  input  logic             a_clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [DAC_W-1:0] code_i,
  input  logic             valid_i,
  input  logic             cfg_i,
  input  logic             sel_i,
  input  logic [23:0]      cfg_data_i,
  output logic             sdi_o
);
  logic [23:0] sr_q, frame_d;

  always_comb begin
    frame_d = 24'h000000;
    if (cfg_i) begin
      if (sel_i) frame_d = cfg_data_i;
    end else if (valid_i) begin
      frame_d = {4'b0001, code_i};
    end
  end

  always_ff @(posedge a_clk) begin
    if (reset)        sr_q <= '0;
    else if (load_i)  sr_q <= frame_d;
    else if (shift_i) sr_q <= {sr_q[22:0], 1'b0};
  end

  // Emptied shift register drives 0 during the last high phase and SYNC_HOLD.
  assign sdi_o = sr_q[23];
endmodule

module axis_dac_spi_seq #(
  parameter int NCH      = 4,
  parameter int IN_W     = 32,
  parameter int DAC_W    = 20,
  parameter int SCLK_DIV = 2,
  parameter int LDAC_W   = 2
) (
  input  logic                 a_clk,
  input  logic                 reset,
  axis_dac_spi_seq_if.slave    axis_i,
  output logic                 dac_sclk,
  output logic                 dac_sync_n,
  output logic [NCH-1:0]       dac_sdi,
  output logic                 dac_ldac_n,
  output logic                 busy,
  output logic [31:0]          frame_count
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SYNC_HOLD, LDAC} state_e;

  localparam logic [15:0] DIV_LAST  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] LDAC_LAST = 16'(LDAC_W - 1);

  state_e      state_q;
  logic        sclk_q, sync_n_q, ldac_n_q, busy_q, cfg_q, send_q;
  logic [4:0]  bit_q;
  logic [15:0] div_q;
  logic [31:0] frame_count_q;
  logic        send_rise, start_norm, start_cfg, load, shift;
  logic        unused_tdata;

  assign send_rise  = axis_i.configuration_send & ~send_q;
  assign start_norm = (state_q == IDLE) & ~axis_i.configuration_mode & (|axis_i.S_AXIS_tvalid);
  assign start_cfg  = (state_q == IDLE) & axis_i.configuration_mode & send_rise;
  assign load       = start_norm | start_cfg;
  // Lanes advance on the SCLK rising edge, leaving a full high+low window per bit.
  assign shift      = (state_q == SHIFT) & ~sclk_q & (div_q == DIV_LAST);
  assign unused_tdata = ^axis_i.S_AXIS_tdata;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    axis_dac_spi_seq_lane #(.DAC_W(DAC_W)) u_lane (
      .a_clk      (a_clk),
      .reset      (reset),
      .load_i     (load),
      .shift_i    (shift),
      .code_i     (axis_i.S_AXIS_tdata[k*IN_W + IN_W-1 -: DAC_W]),
      .valid_i    (axis_i.S_AXIS_tvalid[k]),
      .cfg_i      (axis_i.configuration_mode),
      .sel_i      (axis_i.configuration_axis == 3'(k)),
      .cfg_data_i (axis_i.S_AXISCFG_tdata),
      .sdi_o      (dac_sdi[k])
    );
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sclk_q        <= 1'b1;
      sync_n_q      <= 1'b1;
      ldac_n_q      <= 1'b1;
      busy_q        <= 1'b0;
      cfg_q         <= 1'b0;
      // Treat send as already high so a level held through reset is not an edge.
      send_q        <= 1'b1;
      bit_q         <= '0;
      div_q         <= '0;
      frame_count_q <= '0;
    end else begin
      send_q <= axis_i.configuration_send;
      case (state_q)
        IDLE: if (load) begin
          state_q  <= LOAD;
          sync_n_q <= 1'b0;
          sclk_q   <= 1'b1;
          busy_q   <= 1'b1;
          cfg_q    <= axis_i.configuration_mode;
        end
        LOAD: begin
          state_q <= SHIFT;
          sclk_q  <= 1'b0;
          div_q   <= '0;
          bit_q   <= '0;
        end
        SHIFT: if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (!sclk_q) begin
            sclk_q <= 1'b1;
          end else if (bit_q == 5'd23) begin
            state_q  <= SYNC_HOLD;
            sync_n_q <= 1'b1;
          end else begin
            sclk_q <= 1'b0;
            bit_q  <= bit_q + 5'd1;
          end
        end else begin
          div_q <= div_q + 16'd1;
        end
        SYNC_HOLD: if (div_q == DIV_LAST) begin
          div_q <= '0;
          if (cfg_q) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            frame_count_q <= frame_count_q + 32'd1;
          end else begin
            state_q  <= LDAC;
            ldac_n_q <= 1'b0;
          end
        end else begin
          div_q <= div_q + 16'd1;
        end
        LDAC: if (div_q == LDAC_LAST) begin
          div_q         <= '0;
          state_q       <= IDLE;
          ldac_n_q      <= 1'b1;
          busy_q        <= 1'b0;
          frame_count_q <= frame_count_q + 32'd1;
        end else begin
          div_q <= div_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_sync_n  = sync_n_q;
  assign dac_ldac_n  = ldac_n_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_axis_dac_spi_seq.sv
// Directed bench for axis_dac_spi_seq: normal frames, config frames, dropped
// sends, mode gating and mid-frame reset, with hand-computed frames.
module tb_axis_dac_spi_seq;
  localparam int NCH = 4;

  logic           a_clk = 1'b0;
  logic           reset;
  logic           dac_sclk, dac_sync_n, dac_ldac_n, busy;
  logic [NCH-1:0] dac_sdi;
  logic [31:0]    frame_count;
  int             n_chk = 0;
  int             n_err = 0;

  axis_dac_spi_seq_if #(.NCH(NCH), .IN_W(32)) bus ();

  axis_dac_spi_seq #(.NCH(NCH)) dut (
    .a_clk       (a_clk),
    .reset       (reset),
    .axis_i      (bus),
    .dac_sclk    (dac_sclk),
    .dac_sync_n  (dac_sync_n),
    .dac_sdi     (dac_sdi),
    .dac_ldac_n  (dac_ldac_n),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for busy, then records each lane's bits on SCLK falling
  // edges and the low-time of SYNC_n/LDAC_n until busy drops. Inputs are
  // scrambled mid-frame; optionally a second send edge is attempted.
  task automatic capture(input int toggle_at, output logic [NCH-1:0][23:0] fr,
                         output int nb, output int ns, output int nl);
    int   n = 0;
    logic prev = 1'b1;
    fr = '0; nb = 0; ns = 0; nl = 0;
    while (!busy && n < 20) begin
      @(negedge a_clk);
      n++;
    end
    chk("start", {31'd0, busy}, 32'd1);
    if (!busy) return;
    chk("load_sync_sclk", {30'd0, dac_sync_n, dac_sclk}, 32'b01);
    while (busy && nb < 300) begin
      nb++;
      if (!dac_sync_n) ns++;
      if (!dac_ldac_n) nl++;
      if (prev && !dac_sclk)
        for (int l = 0; l < NCH; l++) fr[l] = {fr[l][22:0], dac_sdi[l]};
      prev = dac_sclk;
      bus.S_AXIS_tvalid = '0;
      bus.S_AXIS_tdata  = {4{32'hDEADBEEF}};
      if (toggle_at != 0 && nb == toggle_at)     bus.configuration_send = 1'b0;
      if (toggle_at != 0 && nb == toggle_at + 2) bus.configuration_send = 1'b1;
      @(negedge a_clk);
    end
  endtask

  logic [NCH-1:0][23:0] fr;
  int nb, ns, nl, cnt;

  initial begin
    reset = 1'b1;
    bus.S_AXIS_tdata       = '0;
    bus.S_AXIS_tvalid      = '0;
    bus.S_AXISCFG_tdata    = '0;
    bus.configuration_mode = 1'b0;
    bus.configuration_axis = '0;
    bus.configuration_send = 1'b0;
    repeat (3) @(negedge a_clk);
    reset = 1'b0;

    // Idle after reset: {sclk,sync_n,ldac_n,busy,sdi}
    for (int i = 0; i < 20; i++) begin
      @(negedge a_clk);
      chk("idle_pins", {24'd0, dac_sclk, dac_sync_n, dac_ldac_n, busy, dac_sdi}, {24'd0, 8'b1110_0000});
      if (i == 19) chk("idle_count", frame_count, 32'd0);
    end

    // Single channel normal frame.
    bus.S_AXIS_tdata  = {32'h0, 32'h0, 32'h0, 32'h12345000};
    bus.S_AXIS_tvalid = 4'b0001;
    capture(0, fr, nb, ns, nl);
    chk("n1_ch0", {8'd0, fr[0]}, 32'h112345);
    chk("n1_ch1", {8'd0, fr[1]}, 32'h0);
    chk("n1_ch3", {8'd0, fr[3]}, 32'h0);
    chk("n1_sync", ns, 32'd97);
    chk("n1_ldac", nl, 32'd2);
    chk("n1_busy", nb, 32'd101);
    chk("n1_count", frame_count, 32'd1);
    chk("n1_idle_pins", {28'd0, dac_sclk, dac_sync_n, dac_ldac_n, 1'b0}, 32'b1110);

    // All channels, sign/extreme values.
    @(negedge a_clk);
    bus.S_AXIS_tdata  = {32'h80000000, 32'h00001FFF, 32'h7FFFF000, 32'hFFFFFFFF};
    bus.S_AXIS_tvalid = 4'b1111;
    capture(0, fr, nb, ns, nl);
    chk("n2_ch0", {8'd0, fr[0]}, 32'h1FFFFF);
    chk("n2_ch1", {8'd0, fr[1]}, 32'h17FFFF);
    chk("n2_ch2", {8'd0, fr[2]}, 32'h100001);
    chk("n2_ch3", {8'd0, fr[3]}, 32'h180000);
    chk("n2_ldac", nl, 32'd2);
    chk("n2_busy", nb, 32'd101);
    chk("n2_count", frame_count, 32'd2);

    // Config frame to channel 2, with a dropped second send edge.
    @(negedge a_clk);
    bus.configuration_mode = 1'b1;
    bus.configuration_axis = 3'd2;
    bus.S_AXISCFG_tdata    = 24'h200012;
    bus.configuration_send = 1'b1;
    capture(10, fr, nb, ns, nl);
    chk("c1_ch2", {8'd0, fr[2]}, 32'h200012);
    chk("c1_ch0", {8'd0, fr[0]}, 32'h0);
    chk("c1_ch3", {8'd0, fr[3]}, 32'h0);
    chk("c1_ldac", nl, 32'd0);
    chk("c1_busy", nb, 32'd99);
    repeat (10) @(negedge a_clk);
    chk("c1_no_requeue", {31'd0, busy}, 32'd0);
    chk("c1_count", frame_count, 32'd3);

    // Config send to an out-of-range channel: all NOP, still counted.
    bus.configuration_send = 1'b0;
    bus.configuration_axis = 3'd5;
    bus.S_AXISCFG_tdata    = 24'hABCDEF;
    repeat (2) @(negedge a_clk);
    bus.configuration_send = 1'b1;
    capture(0, fr, nb, ns, nl);
    chk("c2_all", {fr[3][7:0], fr[2][7:0], fr[1][7:0], fr[0][7:0]} | {8'd0, fr[0] | fr[1] | fr[2] | fr[3]}, 32'h0);
    chk("c2_busy", nb, 32'd99);
    chk("c2_count", frame_count, 32'd4);

    // Config mode suppresses normal updates.
    bus.S_AXIS_tvalid = 4'b1111;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge a_clk);
      if (busy) cnt++;
    end
    chk("cfgmode_block", cnt, 32'd0);
    bus.S_AXIS_tvalid = '0;

    // Reset in the middle of SHIFT.
    bus.configuration_mode = 1'b0;
    bus.configuration_send = 1'b0;
    bus.S_AXIS_tdata  = {32'h0, 32'h0, 32'h0, 32'h7FFFFFFF};
    bus.S_AXIS_tvalid = 4'b0001;
    cnt = 0;
    while (!busy && cnt < 20) begin
      @(negedge a_clk);
      cnt++;
    end
    chk("r_start", {31'd0, busy}, 32'd1);
    bus.S_AXIS_tvalid = '0;
    repeat (44) @(negedge a_clk);
    reset = 1'b1;
    bus.configuration_mode = 1'b1;
    bus.configuration_send = 1'b1;
    @(negedge a_clk);
    chk("rst_pins", {24'd0, dac_sclk, dac_sync_n, dac_ldac_n, busy, dac_sdi}, {24'd0, 8'b1110_0000});
    chk("rst_count", frame_count, 32'd0);
    @(negedge a_clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge a_clk);
      if (busy) cnt++;
    end
    chk("rst_send_held", cnt, 32'd0);

    bus.configuration_mode = 1'b0;
    bus.S_AXIS_tdata  = {32'h0, 32'h0, 32'hABCDE123, 32'h0};
    bus.S_AXIS_tvalid = 4'b0010;
    capture(0, fr, nb, ns, nl);
    chk("r2_ch1", {8'd0, fr[1]}, 32'h1ABCDE);
    chk("r2_ch0", {8'd0, fr[0]}, 32'h0);
    chk("r2_busy", nb, 32'd101);
    chk("r2_count", frame_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
